// File: rtl/pc_fetch_ctrl.sv
// PC sequencer and fetch controller: single outstanding imem request, 2-entry decode buffer, redirect squash.
// Optional misaligned-redirect trap enabled by defining FETCH_MISALIGN_TRAP_EN.
module pc_fetch_ctrl #(
    parameter int unsigned      WIDTH    = 16,
    parameter int unsigned      IW       = 32,
    parameter logic [2:0]       INC      = 3'b100,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             redirect_valid,
    input  logic [WIDTH-1:0] redirect_pc,
    output logic             imem_req_valid,
    input  logic             imem_req_ready,
    output logic [WIDTH-1:0] imem_addr,
    input  logic             imem_rsp_valid,
    input  logic [IW-1:0]    imem_rsp_data,
    output logic             inst_valid,
    input  logic             inst_ready,
    output logic [IW-1:0]    inst_data,
    output logic [WIDTH-1:0] inst_pc,
    output logic             fetch_fault
);

    // Handshakes: a transfer happens on a rising edge where valid && ready are both high;
    // a request holds its address while valid && !ready, except when a redirect replaces it.

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_WAIT  = 3'd2,
        S_HOLD  = 3'd3,
        S_FAULT = 3'd4
    } state_e;

    localparam logic [WIDTH-1:0] ALIGN_MASK = {{(WIDTH-2){1'b1}}, 2'b00};

    state_e           state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] req_pc_q, req_pc_d;
    logic             discard_q, discard_d;
    logic [1:0]       count_q, count_d;
    logic             rd_ptr_q, rd_ptr_d;
    logic             wr_ptr_q, wr_ptr_d;
    logic [IW-1:0]    buf_data_q [2];
    logic [IW-1:0]    buf_data_d [2];
    logic [WIDTH-1:0] buf_pc_q   [2];
    logic [WIDTH-1:0] buf_pc_d   [2];

    logic             redir;
    logic             misalign;
    logic [WIDTH-1:0] target;
    logic             req_fire;
    logic             rsp_in_wait;
    logic             push;
    logic             pop;
    logic [1:0]       occ_after;

    always_comb begin
        redir = redirect_valid && (state_q != S_FAULT);
`ifdef FETCH_MISALIGN_TRAP_EN
        misalign = redir && (redirect_pc[1:0] != 2'b00);
        target   = redirect_pc;
`else
        misalign = 1'b0;
        target   = redirect_pc & ALIGN_MASK;
`endif
        req_fire    = (state_q == S_REQ) && imem_req_ready;
        rsp_in_wait = (state_q == S_WAIT) && imem_rsp_valid;
        push        = rsp_in_wait && !redir && !discard_q;
        pop         = (count_q != 2'd0) && inst_ready;
        occ_after   = count_q + {1'b0, push} - {1'b0, pop};
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; redirect overrides the normal sequence
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  state_d = S_REQ;
            S_REQ:   if (req_fire) state_d = S_WAIT;
            S_WAIT:  if (rsp_in_wait) state_d = (occ_after < 2'd2) ? S_REQ : S_HOLD;
            S_HOLD:  if (occ_after < 2'd2) state_d = S_REQ;
            S_FAULT: state_d = S_FAULT;
            default: state_d = S_IDLE;
        endcase
        if (redir) begin
            if (misalign) begin
                state_d = S_FAULT;
            end else if (state_q == S_WAIT) begin
                state_d = rsp_in_wait ? S_REQ : S_WAIT;
            end else if (state_q == S_REQ) begin
                state_d = req_fire ? S_WAIT : S_REQ;
            end else begin
                state_d = S_REQ;
            end
        end
    end

    // Outputs
    always_comb begin
        imem_req_valid = (state_q == S_REQ);
        imem_addr      = pc_q;
        inst_valid     = (count_q != 2'd0);
        inst_data      = buf_data_q[rd_ptr_q];
        inst_pc        = buf_pc_q[rd_ptr_q];
`ifdef FETCH_MISALIGN_TRAP_EN
        fetch_fault    = (state_q == S_FAULT);
`else
        fetch_fault    = 1'b0;
`endif
    end

    always_comb begin
        pc_d      = pc_q;
        req_pc_d  = req_pc_q;
        discard_d = discard_q;
        count_d   = occ_after;
        rd_ptr_d  = rd_ptr_q;
        wr_ptr_d  = wr_ptr_q;
        buf_data_d = buf_data_q;
        buf_pc_d   = buf_pc_q;

        if (req_fire) begin
            req_pc_d = pc_q;
            pc_d     = pc_q + WIDTH'(INC);
        end
        if (rsp_in_wait && discard_q) begin
            discard_d = 1'b0;
        end
        if (push) begin
            buf_data_d[wr_ptr_q] = imem_rsp_data;
            buf_pc_d[wr_ptr_q]   = req_pc_q;
            wr_ptr_d             = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        // A response still in flight after the redirect belongs to the old path
        if (redir) begin
            pc_d      = target;
            discard_d = ((state_q == S_WAIT) && !imem_rsp_valid && discard_q) ||
                        ((state_q == S_WAIT) && !imem_rsp_valid) || req_fire;
            count_d   = 2'd0;
            rd_ptr_d  = 1'b0;
            wr_ptr_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q      <= RESET_PC;
            req_pc_q  <= RESET_PC;
            discard_q <= 1'b0;
            count_q   <= 2'd0;
            rd_ptr_q  <= 1'b0;
            wr_ptr_q  <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                buf_data_q[i] <= '0;
                buf_pc_q[i]   <= '0;
            end
        end else begin
            pc_q       <= pc_d;
            req_pc_q   <= req_pc_d;
            discard_q  <= discard_d;
            count_q    <= count_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            buf_data_q <= buf_data_d;
            buf_pc_q   <= buf_pc_d;
        end
    end

endmodule
